poly_eval_seq: RTL

Sequential evaluator of the signed quadratic y = a·x² + b·x + c. It is the real responder behind the polynomial test harness's enable/ready/valid protocol, replacing the behavioural stand-in. It uses one shared multiplier and one adder, evaluating in Horner form ((a·x + b)·x + c) over a fixed 5-cycle sequence.

---
 rtl/poly_eval_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/poly_eval_seq.sv
// Sequential signed quadratic evaluator: y = (a*x + b)*x + c, wrapped to 16 bits,
// computed over five cycles with one shared multiplier and one shared adder.
module poly_eval_seq (
   input  logic               clock,
   input  logic               reset,
   input  logic signed [7:0]  x,
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   input  logic signed [15:0] c,
   input  logic               enable,
   output logic signed [15:0] y,
   output logic               ready,
   output logic               valid
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL1 = 3'd1,
      ADD1 = 3'd2,
      MUL2 = 3'd3,
      ADD2 = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] x_q, x_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] c_q, c_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] y_q, y_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;

   // Shared datapath: both multiply steps use x_q, only the left operand is muxed.
   logic [15:0] mul_lhs, mul_res;
   logic [15:0] add_rhs, add_res;

   assign mul_lhs = (state_q == MUL1) ? a_q : acc_q;
   assign mul_res = mul_lhs * x_q;
   assign add_rhs = (state_q == ADD1) ? b_q : c_q;
   assign add_res = acc_q + add_rhs;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      x_d     = x_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      acc_d   = acc_q;
      y_d     = y_q;
      ready_d = ready_q;
      valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               x_d     = {{8{x[7]}}, x};
               a_d     = a;
               b_d     = b;
               c_d     = c;
               ready_d = 1'b0;
               state_d = MUL1;
            end
         end
         MUL1: begin
            acc_d   = mul_res;
            state_d = ADD1;
         end
         ADD1: begin
            acc_d   = add_res;
            state_d = MUL2;
         end
         MUL2: begin
            acc_d   = mul_res;
            state_d = ADD2;
         end
         ADD2: begin
            y_d     = add_res;
            valid_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign y     = y_q;
   assign ready = ready_q;
   assign valid = valid_q;

endmodule
